// File: rtl/sram_xlat_arb.sv
// Multi-channel sramx glue: fixed-mapping MIPS translation, arbitration onto one SRAM port.
// Optional macro SRAM_XLAT_FAULT_EN: kseg2/kseg3 requests are acked but faulted instead of reaching SRAM.
module sram_xlat_arb #(
    parameter int NCH    = 2,
    parameter int DW     = 32,
    parameter int ARB_RR = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*(DW/8)-1:0]  ch_wen,
    input  logic [NCH*32-1:0]      ch_addr,
    input  logic [NCH*DW-1:0]      ch_wdata,
    output logic [NCH-1:0]         ch_addr_ok,
    output logic [NCH-1:0]         ch_data_ok,
    output logic [NCH*DW-1:0]      ch_rdata,
    output logic [NCH-1:0]         ch_fault,
    output logic                   sram_en,
    output logic [(DW/8)-1:0]      sram_wen,
    output logic [31:0]            sram_addr,
    output logic [DW-1:0]          sram_wdata,
    input  logic [DW-1:0]          sram_rdata
);
    localparam int BW  = DW / 8;
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

    // Handshake: a channel holds req/addr/wen/wdata until ch_addr_ok; the
    // response (ch_data_ok) always arrives exactly one cycle after the ack.
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] pend_id_q, pend_id_d;
    logic           pend_v_q, pend_v_d;
    logic [IDW-1:0] gnt_id;
    logic           gnt_v;
    logic           gnt_fault;
    logic [31:0]    gnt_addr;
    logic [31:0]    gnt_paddr;
    logic [BW-1:0]  gnt_wen;
    logic [DW-1:0]  gnt_wdata;

    // Round-robin search starts one past the last winner; fixed mode starts at 0.
    always_comb begin : arbiter
        int c;
        c      = 0;
        gnt_v  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ARB_RR != 0) c = (int'(ptr_q) + 1 + k) % NCH;
            else             c = k;
            if (!gnt_v && ch_req[c]) begin
                gnt_v  = 1'b1;
                gnt_id = IDW'(c);
            end
        end
    end

    assign gnt_addr  = ch_addr[gnt_id*32 +: 32];
    assign gnt_wen   = ch_wen[gnt_id*BW +: BW];
    assign gnt_wdata = ch_wdata[gnt_id*DW +: DW];

    // kseg0 and kseg1 both fold onto the low 512 MB; everything else is identity.
    assign gnt_paddr = (gnt_addr[31:30] == 2'b10) ? {3'b000, gnt_addr[28:0]} : gnt_addr;

`ifdef SRAM_XLAT_FAULT_EN
    assign gnt_fault = gnt_v & (gnt_addr[31:30] == 2'b11);
`else
    assign gnt_fault = 1'b0;
`endif

    assign sram_en    = gnt_v & ~gnt_fault;
    assign sram_wen   = sram_en ? gnt_wen   : '0;
    assign sram_addr  = sram_en ? gnt_paddr : '0;
    assign sram_wdata = sram_en ? gnt_wdata : '0;

    always_comb begin
        pend_v_d  = gnt_v;
        pend_id_d = pend_id_q;
        ptr_d     = ptr_q;
        if (gnt_v) begin
            pend_id_d = gnt_id;
            ptr_d     = gnt_id;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_v_q  <= 1'b0;
            pend_id_q <= '0;
            ptr_q     <= IDW'(NCH - 1);
        end else begin
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef SRAM_XLAT_FAULT_EN
    logic pend_fault_q, pend_fault_d;

    assign pend_fault_d = gnt_fault;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pend_fault_q <= 1'b0;
        else         pend_fault_q <= pend_fault_d;
    end
`endif

    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        ch_rdata   = '0;
        ch_fault   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_v && (gnt_id == IDW'(i))) ch_addr_ok[i] = 1'b1;
            if (pend_v_q && (pend_id_q == IDW'(i))) begin
                ch_data_ok[i] = 1'b1;
`ifdef SRAM_XLAT_FAULT_EN
                if (pend_fault_q) ch_fault[i] = 1'b1;
                else              ch_rdata[i*DW +: DW] = sram_rdata;
`else
                ch_rdata[i*DW +: DW] = sram_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sram_xlat_arb.sv
// Bench for sram_xlat_arb: one round-robin and one fixed-priority instance share the stimulus.
module tb_sram_xlat_arb;
    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int BW  = 4;
`ifdef SRAM_XLAT_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req;
    logic [NCH*BW-1:0] wen;
    logic [NCH*32-1:0] addr;
    logic [NCH*DW-1:0] wdata;

    logic [NCH-1:0]    rr_addr_ok, rr_data_ok, rr_fault;
    logic [NCH*DW-1:0] rr_rdata;
    logic              rr_sram_en;
    logic [BW-1:0]     rr_sram_wen;
    logic [31:0]       rr_sram_addr, rr_sram_wdata, rr_sram_rdata;

    logic [NCH-1:0]    fp_addr_ok, fp_data_ok, fp_fault;
    logic [NCH*DW-1:0] fp_rdata;
    logic              fp_sram_en;
    logic [BW-1:0]     fp_sram_wen;
    logic [31:0]       fp_sram_addr, fp_sram_wdata, fp_sram_rdata;

    sram_xlat_arb #(.NCH(NCH), .DW(DW), .ARB_RR(1)) u_rr (
        .clk(clk), .resetn(resetn), .ch_req(req), .ch_wen(wen), .ch_addr(addr), .ch_wdata(wdata),
        .ch_addr_ok(rr_addr_ok), .ch_data_ok(rr_data_ok), .ch_rdata(rr_rdata), .ch_fault(rr_fault),
        .sram_en(rr_sram_en), .sram_wen(rr_sram_wen), .sram_addr(rr_sram_addr),
        .sram_wdata(rr_sram_wdata), .sram_rdata(rr_sram_rdata)
    );

    sram_xlat_arb #(.NCH(NCH), .DW(DW), .ARB_RR(0)) u_fp (
        .clk(clk), .resetn(resetn), .ch_req(req), .ch_wen(wen), .ch_addr(addr), .ch_wdata(wdata),
        .ch_addr_ok(fp_addr_ok), .ch_data_ok(fp_data_ok), .ch_rdata(fp_rdata), .ch_fault(fp_fault),
        .sram_en(fp_sram_en), .sram_wen(fp_sram_wen), .sram_addr(fp_sram_addr),
        .sram_wdata(fp_sram_wdata), .sram_rdata(fp_sram_rdata)
    );

    // Synchronous SRAM stand-in: read data is a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
    endfunction

    always @(posedge clk) begin
        rr_sram_rdata <= mem_fn(rr_sram_addr);
        fp_sram_rdata <= mem_fn(fp_sram_addr);
    end

    // scoreboard
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: segment mapping, priority order as a rotating list,
    // expected responses as a queue {write, fault, ch[2:0], data[31:0]}.
    function automatic logic [31:0] xlat(input logic [31:0] a);
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
        return a;
    endfunction

    int rr_order[$];
    logic [36:0] exp_q_rr[$];
    logic [36:0] exp_q_fp[$];
    int rr_last_g = -1;

    task automatic model_reset();
        rr_order.delete();
        for (int i = 0; i < NCH; i++) rr_order.push_back(i);
        exp_q_rr.delete();
        exp_q_fp.delete();
        rr_last_g = -1;
    endtask

    function automatic int exp_grant(input int d);
        if (d == 0) begin
            foreach (rr_order[i]) if (req[rr_order[i]]) return rr_order[i];
        end else begin
            for (int c = 0; c < NCH; c++) if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_dut(input int d, input string ph);
        logic [NCH-1:0]    a_ok, d_ok, flt;
        logic [NCH*DW-1:0] rd;
        logic              en;
        logic [BW-1:0]     sw;
        logic [31:0]       sa, sd, ga, pa, ex;
        logic [36:0]       e;
        logic              gf, gw, have;
        int                g, ech;
        string             nm;
        if (d == 0) begin
            a_ok = rr_addr_ok; d_ok = rr_data_ok; flt = rr_fault; rd = rr_rdata;
            en = rr_sram_en; sw = rr_sram_wen; sa = rr_sram_addr; sd = rr_sram_wdata; nm = "rr";
        end else begin
            a_ok = fp_addr_ok; d_ok = fp_data_ok; flt = fp_fault; rd = fp_rdata;
            en = fp_sram_en; sw = fp_sram_wen; sa = fp_sram_addr; sd = fp_sram_wdata; nm = "fp";
        end
        g  = exp_grant(d);
        ga = (g >= 0) ? addr[g*32 +: 32] : 32'h0;
        gw = (g >= 0) ? (|wen[g*BW +: BW]) : 1'b0;
        gf = FAULT_EN && (g >= 0) && (ga[31:30] == 2'b11);
        pa = xlat(ga);
        check_eq({nm, "/", ph, "/addr_ok"}, 32'(a_ok), (g >= 0) ? (32'd1 << g) : 32'd0);
        check_eq({nm, "/", ph, "/sram_en"}, 32'(en), 32'((g >= 0) && !gf));
        if (g < 0 || !gf) begin
            check_eq({nm, "/", ph, "/sram_addr"},  sa, (g >= 0) ? pa : 32'h0);
            check_eq({nm, "/", ph, "/sram_wen"},   32'(sw), (g >= 0) ? 32'(wen[g*BW +: BW]) : 32'h0);
            check_eq({nm, "/", ph, "/sram_wdata"}, sd, (g >= 0) ? wdata[g*DW +: DW] : 32'h0);
        end

        have = 1'b0;
        e    = '0;
        if (d == 0 && exp_q_rr.size() > 0) begin e = exp_q_rr.pop_front(); have = 1'b1; end
        if (d == 1 && exp_q_fp.size() > 0) begin e = exp_q_fp.pop_front(); have = 1'b1; end
        ech = int'(e[34:32]);
        check_eq({nm, "/", ph, "/data_ok"}, 32'(d_ok), have ? (32'd1 << ech) : 32'd0);
        check_eq({nm, "/", ph, "/fault"},   32'(flt), (have && e[35]) ? (32'd1 << ech) : 32'd0);
        for (int c = 0; c < NCH; c++) begin
            if (!(have && c == ech && e[36] && !e[35])) begin
                ex = (have && c == ech) ? e[31:0] : 32'h0;
                check_eq($sformatf("%s/%s/rdata%0d", nm, ph, c), rd[c*DW +: DW], ex);
            end
        end

        if (g >= 0) begin
            e = {gw, gf, 3'(g), gf ? 32'h0 : mem_fn(pa)};
            if (d == 0) exp_q_rr.push_back(e);
            else        exp_q_fp.push_back(e);
        end
        if (d == 0) begin
            rr_last_g = g;
            if (g >= 0) while (rr_order[$] != g) rr_order.push_back(rr_order.pop_front());
        end
    endtask

    // driver tasks
    task automatic step(input string ph);
        #1;
        check_dut(0, ph);
        check_dut(1, ph);
        @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic r, input logic [BW-1:0] w,
                          input logic [31:0] a, input logic [31:0] dat);
        req[c]             = r;
        wen[c*BW +: BW]    = w;
        addr[c*32 +: 32]   = a;
        wdata[c*DW +: DW]  = dat;
    endtask

    task automatic idle();
        req = '0; wen = '0; addr = '0; wdata = '0;
    endtask

    logic [NCH-1:0] cont_rr [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
    logic           hold [NCH];

    initial begin
        idle();
        model_reset();
        resetn = 1'b0;
        @(negedge clk);
        step("reset");
        resetn = 1'b1;
        step("idle");

        // single kseg1 read on ch0
        set_ch(0, 1'b1, 4'h0, 32'hBFC0_0000, 32'h0);
        #1;
        check_eq("t1_sram_addr", rr_sram_addr, 32'h1FC0_0000);
        check_eq("t1_addr_ok", 32'(rr_addr_ok), 32'h1);
        step("t1_req");
        idle();
        #1;
        check_eq("t1_data_ok", 32'(rr_data_ok), 32'h1);
        check_eq("t1_rdata", rr_rdata[31:0], mem_fn(32'h1FC0_0000));
        step("t1_rsp");

        // kseg0 partial write on ch1
        set_ch(1, 1'b1, 4'b0011, 32'h8000_1004, 32'hDEAD_BEEF);
        #1;
        check_eq("t2_sram_addr", rr_sram_addr, 32'h0000_1004);
        check_eq("t2_sram_wen", 32'(rr_sram_wen), 32'h3);
        check_eq("t2_sram_wdata", rr_sram_wdata, 32'hDEAD_BEEF);
        step("t2_req");
        idle();
        #1;
        check_eq("t2_data_ok", 32'(rr_data_ok), 32'h2);
        step("t2_rsp");

        // contention: ch0 and ch1 both requesting for 4 cycles
        for (int i = 0; i < 4; i++) begin
            set_ch(0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
            set_ch(1, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
            #1;
            check_eq($sformatf("cont_rr%0d", i), 32'(rr_addr_ok), 32'(cont_rr[i]));
            check_eq($sformatf("cont_fp%0d", i), 32'(fp_addr_ok), 32'h1);
            step("cont");
        end
        idle();
        step("cont_drain");

        // back-to-back reads on ch0
        set_ch(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        step("b2b_0");
        set_ch(0, 1'b1, 4'h0, 32'h0000_0014, 32'h0);
        #1;
        check_eq("b2b_en", 32'(rr_sram_en), 32'h1);
        check_eq("b2b_rdata0", rr_rdata[31:0], mem_fn(32'h0000_0010));
        step("b2b_1");
        idle();
        #1;
        check_eq("b2b_rdata1", rr_rdata[31:0], mem_fn(32'h0000_0014));
        step("b2b_drain");

        // reset while an access is in flight
        set_ch(0, 1'b1, 4'h0, 32'h0000_0020, 32'h0);
        #1;
        check_dut(0, "rst_req");
        check_dut(1, "rst_req");
        #1;
        resetn = 1'b0;
        idle();
        model_reset();
        #1;
        check_dut(0, "in_rst");
        check_dut(1, "in_rst");
        @(negedge clk);
        resetn = 1'b1;
        step("post_rst");
        set_ch(0, 1'b1, 4'h0, 32'h0000_0030, 32'h0);
        set_ch(1, 1'b1, 4'h0, 32'h0000_0034, 32'h0);
        #1;
        check_eq("rst_ptr", 32'(rr_addr_ok), 32'h1);
        step("rst_arb");
        idle();
        step("rst_drain");

        // kseg2 read: faulted or identity-mapped depending on the build
        set_ch(0, 1'b1, 4'h0, 32'hC000_0000, 32'h0);
        #1;
        check_eq("flt_sram_en", 32'(rr_sram_en), 32'(!FAULT_EN));
        step("flt_req");
        idle();
        #1;
        check_eq("flt_fault", 32'(rr_fault), 32'(FAULT_EN));
        step("flt_rsp");

        // randomized traffic following the round-robin instance's handshake
        for (int i = 0; i < NCH; i++) hold[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                logic [2:0] seg;
                if (hold[c] && rr_last_g == c) hold[c] = 1'b0;
                if (hold[c] && $urandom_range(0, 19) == 0) begin
                    hold[c] = 1'b0;
                    req[c]  = 1'b0;
                end else begin
                    if (!hold[c] && $urandom_range(0, 9) < 6) begin
                        seg = 3'($urandom_range(0, 7));
                        set_ch(c, 1'b1,
                               ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                               {seg, 29'($urandom) & 29'h1FFF_FFFC}, $urandom);
                        hold[c] = 1'b1;
                    end
                    req[c] = hold[c];
                end
            end
            step("rand");
        end
        idle();
        step("final_drain");
        step("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
